// File: rtl/eq_gain_sequencer.sv
// eq_gain_sequencer: three-band equalizer gain sequencer.
//   Gain writes set per-band targets. On each sample strobe every current gain
//   moves toward its effective target by at most STEP, clamping so it never
//   overshoots. A level mute request forces all effective targets to 0.
// Ports:
//   clk, reset (async, active low)
//   sample_valid                   ramp tick, one per audio sample
//   cmd_valid/cmd_ready            gain write handshake
//   cmd_band[1:0], cmd_gain[7:0]   band select (3 is illegal) and target gain
//   mute_req                       level-sensitive mute
//   gain_low/mid/high[7:0]         registered current gains
//   busy, muted, cmd_err           status; cmd_err pulses on an illegal band

// One band: target register, current register and the clamped ramp step.
module eq_gain_lane #(
  parameter int unsigned STEP       = 4,
  parameter logic [7:0]  RESET_GAIN = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       tgt_we,
  input  logic [7:0] tgt_wdata,
  input  logic       force_zero,
  output logic [7:0] cur,
  output logic       at_eff,
  output logic       is_zero
);
  logic [7:0] tgt_q, cur_q, cur_d, eff;
  logic [8:0] up9, floor9;

  assign eff = force_zero ? 8'd0 : tgt_q;
  // 9-bit sums: cur+STEP and eff+STEP cannot wrap, so the clamp compares are exact.
  assign up9    = {1'b0, cur_q} + 9'(STEP);
  assign floor9 = {1'b0, eff}   + 9'(STEP);

  always_comb begin
    cur_d = cur_q;
    if (tick) begin
      if (cur_q < eff)
        cur_d = (up9 > {1'b0, eff}) ? eff : up9[7:0];
      else if (cur_q > eff)
        cur_d = ({1'b0, cur_q} < floor9) ? eff : cur_q - 8'(STEP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q <= RESET_GAIN;
      cur_q <= RESET_GAIN;
    end else begin
      // Ramp uses the old target this cycle; a same-cycle write lands next cycle.
      if (tgt_we) tgt_q <= tgt_wdata;
      cur_q <= cur_d;
    end
  end

  assign cur     = cur_q;
  assign at_eff  = (cur_q == eff);
  assign is_zero = (cur_q == 8'd0);
endmodule

module eq_gain_sequencer #(
  parameter int unsigned STEP       = 4,
  parameter logic [7:0]  RESET_GAIN = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_band,
  input  logic [7:0] cmd_gain,
  input  logic       mute_req,
  output logic [7:0] gain_low,
  output logic [7:0] gain_mid,
  output logic [7:0] gain_high,
  output logic       busy,
  output logic       muted,
  output logic       cmd_err
);
  localparam int NUM_BANDS = 3;

  typedef enum logic [1:0] {IDLE, RAMP, MUTING, MUTED} state_t;
  state_t state_q, state_d;

  logic [NUM_BANDS-1:0][7:0] cur;
  logic [NUM_BANDS-1:0]      at_eff, is_zero, tgt_we;
  logic                      cmd_acc, force_zero, busy_d, muted_d;

  // Ready is simply "out of reset": the block never back-pressures writes.
  assign cmd_ready  = reset;
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign force_zero = (state_q == MUTING) || (state_q == MUTED);

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    assign tgt_we[b] = cmd_acc && (cmd_band == 2'(b));
    eq_gain_lane #(.STEP(STEP), .RESET_GAIN(RESET_GAIN)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .tick       (sample_valid),
      .tgt_we     (tgt_we[b]),
      .tgt_wdata  (cmd_gain),
      .force_zero (force_zero),
      .cur        (cur[b]),
      .at_eff     (at_eff[b]),
      .is_zero    (is_zero[b])
    );
  end

  assign gain_low  = cur[0];
  assign gain_mid  = cur[1];
  assign gain_high = cur[2];

  // State register; busy/muted are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      muted   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      muted   <= muted_d;
    end
  end

  // Next state: mute_req dominates every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mute_req) state_d = MUTING;
               else if (!(&at_eff)) state_d = RAMP;
      RAMP:    if (mute_req) state_d = MUTING;
               else if (&at_eff) state_d = IDLE;
      MUTING:  if (!mute_req) state_d = RAMP;
               else if (&is_zero) state_d = MUTED;
      MUTED:   if (!mute_req) state_d = RAMP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state being entered, so they line up with state_q.
  always_comb begin
    busy_d  = (state_d == RAMP) || (state_d == MUTING);
    muted_d = (state_d == MUTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd_err <= 1'b0;
    else        cmd_err <= cmd_acc && (cmd_band == 2'd3);
  end
endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Scoreboard bench for eq_gain_sequencer: each driven cycle pushes the
// expected post-edge outputs from a behavioural model; a monitor pops and
// compares one entry per clock. Directed spot checks use literal values.
module tb_eq_gain_sequencer;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_valid = 1'b0, cmd_valid = 1'b0, mute_req = 1'b0;
  logic [1:0] cmd_band = '0;
  logic [7:0] cmd_gain = '0;
  logic       cmd_ready, busy, muted, cmd_err;
  logic [7:0] gain_low, gain_mid, gain_high;

  eq_gain_sequencer #(.STEP(STEP), .RESET_GAIN(8'h40)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_band(cmd_band),
    .cmd_gain(cmd_gain), .mute_req(mute_req), .gain_low(gain_low),
    .gain_mid(gain_mid), .gain_high(gain_high), .busy(busy),
    .muted(muted), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lo, mid, hi;
    logic busy, muted, err, ready;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: gains as plain integers, mute as "active since the cycle after mute_req".
  int m_tgt[3], m_cur[3];
  bit m_mact, m_mted, m_bsy, m_err;

  function automatic int clampstep(input int c, input int e);
    if (c < e) return (c + STEP > e) ? e : c + STEP;
    if (c > e) return (c - STEP < e) ? e : c - STEP;
    return c;
  endfunction

  task automatic model_step();
    exp_t e;
    int eff[3];
    bit allzero, anyne;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin m_tgt[i] = 64; m_cur[i] = 64; end
      m_mact = 0; m_mted = 0; m_bsy = 0; m_err = 0;
    end else begin
      allzero = 1; anyne = 0;
      for (int i = 0; i < 3; i++) begin
        eff[i] = m_mact ? 0 : m_tgt[i];
        if (m_cur[i] != 0) allzero = 0;
        if (m_cur[i] != eff[i]) anyne = 1;
      end
      if (sample_valid)
        for (int i = 0; i < 3; i++) m_cur[i] = clampstep(m_cur[i], eff[i]);
      if (cmd_valid && cmd_band != 2'd3) m_tgt[cmd_band] = int'(cmd_gain);
      m_err  = cmd_valid && (cmd_band == 2'd3);
      m_mted = mute_req && m_mact && allzero;
      m_bsy  = mute_req ? !m_mted : (m_mact || anyne);
      m_mact = mute_req;
    end
    e.lo = 8'(m_cur[0]); e.mid = 8'(m_cur[1]); e.hi = 8'(m_cur[2]);
    e.busy = m_bsy; e.muted = m_mted; e.err = m_err; e.ready = reset;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gain_low",  int'(gain_low),  int'(e.lo));
      chk("gain_mid",  int'(gain_mid),  int'(e.mid));
      chk("gain_high", int'(gain_high), int'(e.hi));
      chk("busy",      int'(busy),      int'(e.busy));
      chk("muted",     int'(muted),     int'(e.muted));
      chk("cmd_err",   int'(cmd_err),   int'(e.err));
      chk("cmd_ready", int'(cmd_ready), int'(e.ready));
    end
  end

  logic rst_lvl = 1'b0, mute_lvl = 1'b0;

  // Drive one cycle's inputs at the falling edge and record the model's prediction.
  task automatic cyc(input bit sv, input bit cv, input int band, input int gain);
    @(negedge clk);
    reset = rst_lvl; mute_req = mute_lvl;
    sample_valid = sv; cmd_valid = cv;
    cmd_band = 2'(band); cmd_gain = 8'(gain);
    model_step();
  endtask

  task automatic wr(input int band, input int gain); cyc(0, 1, band, gain); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 0, 0, 0); endtask
  task automatic strobes(input int n); repeat (n) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end endtask
  task automatic settle(); @(posedge clk); #2; endtask

  initial begin
    // Reset held
    rst_lvl = 0;
    idle(3);
    #1;
    chk("rst_gain_low", int'(gain_low), 64);
    chk("rst_gain_high", int'(gain_high), 64);
    chk("rst_ready", int'(cmd_ready), 0);
    rst_lvl = 1;
    idle(2);
    settle();
    chk("ready_after_release", int'(cmd_ready), 1);

    // Up-ramp band0 to 80
    wr(0, 80);
    strobes(4);
    idle(2);
    settle();
    chk("upramp_low", int'(gain_low), 80);
    chk("upramp_mid", int'(gain_mid), 64);
    chk("upramp_busy", int'(busy), 0);

    // Clamping
    wr(2, 66);
    strobes(1);
    settle();
    chk("clamp_high", int'(gain_high), 66);
    wr(1, 1);
    strobes(15);
    settle();
    chk("clamp_mid_15", int'(gain_mid), 4);
    strobes(1);
    settle();
    chk("clamp_mid_16", int'(gain_mid), 1);

    // Back to 64/64/64
    wr(0, 64); wr(1, 64); wr(2, 64);
    strobes(18);
    idle(2);

    // Mute
    mute_lvl = 1;
    idle(1);
    strobes(16);
    idle(2);
    settle();
    chk("mute_low", int'(gain_low), 0);
    chk("mute_muted", int'(muted), 1);
    wr(0, 100);
    strobes(3);
    settle();
    chk("muted_hold_low", int'(gain_low), 0);
    mute_lvl = 0;
    idle(1);
    strobes(16);
    settle();
    chk("unmute_mid", int'(gain_mid), 64);
    strobes(9);
    idle(2);
    settle();
    chk("unmute_low", int'(gain_low), 100);
    chk("unmute_busy", int'(busy), 0);

    // Illegal band, then same-cycle write + strobe
    wr(3, 9);
    idle(1);
    wr(0, 64);
    strobes(9);
    idle(2);
    cyc(1, 1, 0, 72);
    settle();
    chk("samecyc_low0", int'(gain_low), 64);
    strobes(1);
    settle();
    chk("samecyc_low1", int'(gain_low), 68);
    strobes(1);
    settle();
    chk("samecyc_low2", int'(gain_low), 72);

    // Reset mid-ramp
    wr(0, 200);
    strobes(5);
    rst_lvl = 0;
    idle(1);
    #1;
    chk("midramp_rst_low", int'(gain_low), 64);
    idle(2);
    rst_lvl = 1;
    strobes(5);
    settle();
    chk("post_rst_low", int'(gain_low), 64);
    chk("post_rst_busy", int'(busy), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) mute_lvl = ~mute_lvl;
      rst_lvl = ($urandom_range(299) != 0);
      cyc($urandom_range(99) < 35, $urandom_range(99) < 20,
          int'($urandom_range(3)), int'($urandom_range(255)));
    end
    rst_lvl = 1; mute_lvl = 0;
    idle(4);
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
